// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage and its consumers.
// Contents:
//   - RV32 major opcode constants (also used by decode and the immediate generator)
//   - RESET_PC_DEFAULT: default PC after reset
//   - fetch_entry_t: one buffered instruction with the PC it was fetched from
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, the branch unit
// and decode. Signal names carry the direction as seen from the fetch stage.
//
// Handshakes:
//   imem: a request transfers in a cycle with imem_req_o && imem_gnt_i; once
//         raised, imem_req_o and imem_addr_o hold until granted. Responses
//         (imem_rvalid_i/imem_rdata_i) return in request order, at least one
//         cycle after the grant, and are not back-pressured.
//   id:   an instruction transfers in a cycle with id_valid_o && id_ready_i;
//         while id_valid_o && !id_ready_i the PC and fields hold.
//
// Modports: master = fetch stage, slave = environment (memory/decode/branch).
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [2:0]  funct3_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [6:0]  funct7_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        output id_valid_o, id_pc_o, opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o,
        input  id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        input  id_valid_o, id_pc_o, opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o,
        output id_ready_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   flush_i              empties the FIFO (wins over push/pop)
//   push_i, wdata_i      write; accepted when not full, or when full and popping
//   pop_i                read-advance; ignored when empty
//   rdata_o              registered head entry
//   full_o, empty_o      status
//   count_o              number of stored entries
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        // When full, a push is only legal together with a pop; the slot being
        // written is the one the head is leaving.
        do_push  = push_i && (!full_o || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (!flush_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory, buffers returned words with their PCs and presents split fields to
// decode. Redirects flush the buffer and discard responses still in flight.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  async active-low reset
//   bus     fetch_unit_if.master: imem req/gnt/rvalid, redirect, id valid/ready + fields
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input logic          clk_i,
    input logic          rst_ni,
    fetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic          run_q;
    logic [31:0]   pc_q, pc_d;
    logic          pend_q, pend_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic [CW-1:0] discard_q, discard_d;

    logic          pcq_full, pcq_empty;
    logic [CW-1:0] pcq_count;
    logic [31:0]   pcq_head;
    logic          buf_full, buf_empty;
    logic [CW-1:0] buf_count;
    fetch_entry_t  buf_head, buf_wdata, out_entry;

    logic          req, gnt_fire, rv_fire, pop_fire, buf_push;
    logic [SW-1:0] in_use, outs_next;
    logic [31:0]   redirect_tgt;

    // The PC queue holds one PC per granted-but-unanswered request, so its
    // count is the outstanding-request counter.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .push_i  (gnt_fire),
        .wdata_i (pc_q),
        .pop_i   (rv_fire),
        .rdata_o (pcq_head),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (pcq_count)
    );

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fetch_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (bus.redirect_i),
        .push_i  (buf_push),
        .wdata_i (buf_wdata),
        .pop_i   (pop_fire),
        .rdata_o (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    always_comb begin
        redirect_tgt = bus.redirect_pc_i & ~32'h3;
        pop_fire     = !buf_empty && bus.id_ready_i;
        // Credit: in-flight plus buffered words, with this cycle's pop freed.
        in_use       = SW'(pcq_count) + SW'(buf_count) - SW'(pop_fire);
        // run_q keeps the request low for the first cycle after reset release.
        req          = run_q && (in_use < SW'(DEPTH));
        gnt_fire     = req && bus.imem_gnt_i;
        // A response with nothing outstanding is a leftover from before reset.
        rv_fire      = bus.imem_rvalid_i && !pcq_empty;
        buf_push     = rv_fire && (discard_q == '0) && !bus.redirect_i;
        buf_wdata    = '{pc: pcq_head, instr: bus.imem_rdata_i};
        outs_next    = SW'(pcq_count) + SW'(gnt_fire) - SW'(rv_fire);

        discard_d = discard_q;
        if (bus.redirect_i) begin
            discard_d = CW'(outs_next);
        end else begin
            if (rv_fire && discard_q != '0) discard_d = discard_d - CW'(1);
            // A request that was already on the bus when a redirect arrived
            // is granted with its stale address; drop its answer too.
            if (gnt_fire && pend_q) discard_d = discard_d + CW'(1);
        end

        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (gnt_fire) begin
            if (bus.redirect_i)  pc_d = redirect_tgt;
            else if (pend_q)     pc_d = pend_pc_q;
            else                 pc_d = pc_q + 32'd4;
            pend_d = 1'b0;
        end else if (bus.redirect_i) begin
            if (req) begin
                // Address must hold until granted; park the target.
                pend_d    = 1'b1;
                pend_pc_d = redirect_tgt;
            end else begin
                pc_d   = redirect_tgt;
                pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q     <= 1'b0;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            discard_q <= '0;
        end else begin
            run_q     <= 1'b1;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            discard_q <= discard_d;
        end
    end

    assign out_entry       = buf_empty ? '0 : buf_head;
    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc_q;
    assign bus.id_valid_o  = !buf_empty;
    assign bus.id_pc_o     = out_entry.pc;
    assign bus.opcode_o    = out_entry.instr[6:0];
    assign bus.rd_o        = out_entry.instr[11:7];
    assign bus.funct3_o    = out_entry.instr[14:12];
    assign bus.rs1_o       = out_entry.instr[19:15];
    assign bus.rs2_o       = out_entry.instr[24:20];
    assign bus.funct7_o    = out_entry.instr[31:25];

    // In-flight plus buffered never exceeds DEPTH.
    assert property (@(posedge clk_i) disable iff (!rst_ni) buf_full |-> pcq_empty);
    assert property (@(posedge clk_i) disable iff (!rst_ni) pcq_full |-> buf_empty);

endmodule
